hqm_list_sel_mem_rf_pg_ctl: RTL and testbench

HQM_LIST_SEL_MEM_RF_PG_CTL -- requirements
Module: hqm_list_sel_mem_rf_pg_ctl

---
 rtl/hqm_list_sel_mem_rf_pg_ctl.sv | 175 +++++++++++++++++
 tb/tb_hqm_list_sel_mem_rf_pg_ctl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hqm_list_sel_mem_rf_pg_ctl.sv
// Power-gating controller for the list-select register file: sequences RF power
// and isolation, then arbitrates two read requesters and one writer onto the RF ports.
module hqm_list_sel_mem_rf_pg_ctl #(
    parameter int PWRUP_CYC = 8,
    parameter int ISOL_CYC  = 2,
    parameter int IDLE_TO   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_pg_en,
    input  logic        rd0_v,
    input  logic [4:0]  rd0_addr,
    output logic        rd0_rdy,
    input  logic        rd1_v,
    input  logic [4:0]  rd1_addr,
    output logic        rd1_rdy,
    input  logic        wr_v,
    input  logic [4:0]  wr_addr,
    input  logic [95:0] wr_data,
    output logic        wr_rdy,
    output logic        rdata_v,
    output logic        rdata_id,
    output logic [95:0] rdata,
    output logic        mem_we,
    output logic [4:0]  mem_waddr,
    output logic [95:0] mem_wdata,
    output logic        mem_re,
    output logic [4:0]  mem_raddr,
    input  logic [95:0] mem_rdata,
    output logic        pgcb_isol_en,
    output logic        pwr_enable_b_in,
    input  logic        pwr_enable_b_out,
    output logic [2:0]  pwr_state
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_PWRUP = 3'd1,
        ST_ISOL  = 3'd2,
        ST_ON    = 3'd3,
        ST_PWRDN = 3'd4
    } pwr_state_t;

    localparam int          CNT_W      = 16;
    localparam logic [31:0] PWRUP_LAST = (PWRUP_CYC > 1) ? 32'(PWRUP_CYC - 1) : 32'd0;
    localparam logic [31:0] ISOL_LAST  = (ISOL_CYC > 1) ? 32'(ISOL_CYC - 1) : 32'd0;
    localparam logic [31:0] IDLE_LIM   = 32'(IDLE_TO);
    localparam logic        IDLE_EN    = (IDLE_TO != 0);

    pwr_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       idle_q, idle_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             rdata_v_q, rdata_v_d;
    logic             rdata_id_q, rdata_id_d;

    logic             is_on;
    logic             any_req;
    logic             rd_cand_v;
    logic             rd_cand_id;
    logic [4:0]       rd_cand_addr;
    logic             rd_block;
    logic             rd_gnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      cnt_ext;
    logic [31:0]      idle_ext;

    assign is_on    = (state_q == ST_ON);
    assign any_req  = rd0_v | rd1_v | wr_v;
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign cnt_ext  = {{(32-CNT_W){1'b0}}, cnt_q};
    assign idle_ext = {25'd0, idle_q};

    // Handshake: a requester holds v and its address until it sees rdy; the
    // transfer happens in the cycle where v & rdy, and rdy may depend on v.
    always_comb begin
        rd_cand_v  = rd0_v | rd1_v;
        rd_cand_id = 1'b0;
        if (rd0_v && rd1_v) begin
            rd_cand_id = rr_ptr_q;
        end else if (rd1_v) begin
            rd_cand_id = 1'b1;
        end
        rd_cand_addr = rd_cand_id ? rd1_addr : rd0_addr;
        // A same-address write wins; the other reader is not promoted in its place.
        rd_block = wr_v && (wr_addr == rd_cand_addr);
        rd_gnt   = is_on && rd_cand_v && !rd_block;
        rr_ptr_d = rr_ptr_q;
        if (rd_gnt && rd0_v && rd1_v) begin
            rr_ptr_d = ~rr_ptr_q;
        end
        rdata_v_d  = rd_gnt;
        rdata_id_d = rd_gnt ? rd_cand_id : rdata_id_q;
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = '0;
        idle_d          = '0;
        pgcb_isol_en    = 1'b1;
        pwr_enable_b_in = 1'b0;
        case (state_q)
            ST_OFF: begin
                pwr_enable_b_in = 1'b1;
                if (any_req || !cfg_pg_en) begin
                    state_d = ST_PWRUP;
                end
            end
            ST_PWRUP: begin
                if ((cnt_ext >= PWRUP_LAST) && !pwr_enable_b_out) begin
                    state_d = ST_ISOL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ISOL: begin
                if (cnt_ext >= ISOL_LAST) begin
                    state_d = ST_ON;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ON: begin
                pgcb_isol_en = 1'b0;
                if (any_req) begin
                    idle_d = '0;
                end else begin
                    idle_d = (idle_q == 7'h7f) ? idle_q : idle_q + 7'd1;
                end
                // rdata_v_q doubles as "a read was issued last cycle".
                if (cfg_pg_en && IDLE_EN && (idle_ext >= IDLE_LIM) && !rdata_v_q) begin
                    state_d = ST_PWRDN;
                end
            end
            ST_PWRDN: begin
                state_d = ST_OFF;
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            idle_q     <= '0;
            rr_ptr_q   <= 1'b0;
            rdata_v_q  <= 1'b0;
            rdata_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            rr_ptr_q   <= rr_ptr_d;
            rdata_v_q  <= rdata_v_d;
            rdata_id_q <= rdata_id_d;
        end
    end

    assign rd0_rdy   = rd_gnt & ~rd_cand_id;
    assign rd1_rdy   = rd_gnt & rd_cand_id;
    assign wr_rdy    = is_on & wr_v;
    assign mem_we    = wr_rdy;
    assign mem_waddr = wr_addr;
    assign mem_wdata = wr_data;
    assign mem_re    = rd_gnt;
    assign mem_raddr = rd_cand_addr;
    assign rdata_v   = rdata_v_q;
    assign rdata_id  = rdata_id_q;
    assign rdata     = mem_rdata;
    assign pwr_state = state_q;

endmodule

// File: tb/tb_hqm_list_sel_mem_rf_pg_ctl.sv
// Directed and randomized bench for the RF power-gating controller, with a
// behavioural RF model and a request/response scoreboard.
module tb_hqm_list_sel_mem_rf_pg_ctl;

    localparam int PWRUP_CYC = 8;
    localparam int ISOL_CYC  = 2;
    localparam int IDLE_TO   = 64;

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_PWRUP = 3'd1;
    localparam logic [2:0] S_ISOL  = 3'd2;
    localparam logic [2:0] S_ON    = 3'd3;
    localparam logic [2:0] S_PWRDN = 3'd4;

    logic        clk;
    logic        rst;
    logic        cfg_pg_en;
    logic        rd0_v, rd1_v, wr_v;
    logic [4:0]  rd0_addr, rd1_addr, wr_addr;
    logic [95:0] wr_data;
    logic        rd0_rdy, rd1_rdy, wr_rdy;
    logic        rdata_v, rdata_id;
    logic [95:0] rdata;
    logic        mem_we, mem_re;
    logic [4:0]  mem_waddr, mem_raddr;
    logic [95:0] mem_wdata;
    logic [95:0] mem_rdata;
    logic        pgcb_isol_en, pwr_enable_b_in, pwr_enable_b_out;
    logic [2:0]  pwr_state;
    logic        echo_hold_high;

    int          errors;
    int          checks;
    logic        fav;
    logic        last_g0, last_g1;
    logic        p0, p1;
    logic [95:0] ref_mem [32];
    logic [96:0] exp_q[$];
    logic [95:0] rf [32];

    hqm_list_sel_mem_rf_pg_ctl #(
        .PWRUP_CYC(PWRUP_CYC),
        .ISOL_CYC (ISOL_CYC),
        .IDLE_TO  (IDLE_TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_pg_en       (cfg_pg_en),
        .rd0_v           (rd0_v),
        .rd0_addr        (rd0_addr),
        .rd0_rdy         (rd0_rdy),
        .rd1_v           (rd1_v),
        .rd1_addr        (rd1_addr),
        .rd1_rdy         (rd1_rdy),
        .wr_v            (wr_v),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_rdy          (wr_rdy),
        .rdata_v         (rdata_v),
        .rdata_id        (rdata_id),
        .rdata           (rdata),
        .mem_we          (mem_we),
        .mem_waddr       (mem_waddr),
        .mem_wdata       (mem_wdata),
        .mem_re          (mem_re),
        .mem_raddr       (mem_raddr),
        .mem_rdata       (mem_rdata),
        .pgcb_isol_en    (pgcb_isol_en),
        .pwr_enable_b_in (pwr_enable_b_in),
        .pwr_enable_b_out(pwr_enable_b_out),
        .pwr_state       (pwr_state)
    );

    // Clock and power-good echo
    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign pwr_enable_b_out = pwr_enable_b_in | echo_hold_high;

    // Register file: one-cycle registered read, cleared with the block reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_we) rf[mem_waddr] <= mem_wdata;
            if (mem_re) mem_rdata <= rf[mem_raddr];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        exp_q.delete();
        fav = 1'b0;
    endtask

    // Power-state outputs follow from the state alone; nothing may move outside ON
    task automatic chk_pwr(input string tag, input logic [2:0] st);
        chk({tag, ":state"}, 128'(pwr_state), 128'(st));
        chk({tag, ":isol"}, 128'(pgcb_isol_en), 128'(st != S_ON));
        chk({tag, ":pwren_b"}, 128'(pwr_enable_b_in), 128'(st == S_OFF));
        if (st != S_ON)
            chk({tag, ":quiet"}, 128'({rd0_rdy, rd1_rdy, wr_rdy, mem_we, mem_re}), 128'(0));
    endtask

    // One ON cycle: scoreboard the previous grant's return, predict this cycle's grants
    task automatic on_cycle(input string tag);
        logic [96:0] e;
        logic        win, g0, g1;
        logic [4:0]  raddr;
        #1;
        chk({tag, ":state"}, 128'(pwr_state), 128'(S_ON));
        chk({tag, ":isol"}, 128'(pgcb_isol_en), 128'(0));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, ":rdata_v"}, 128'(rdata_v), 128'(1));
            chk({tag, ":rdata_id"}, 128'(rdata_id), 128'(e[96]));
            chk({tag, ":rdata"}, 128'(rdata), 128'(e[95:0]));
        end else begin
            chk({tag, ":rdata_v_idle"}, 128'(rdata_v), 128'(0));
        end
        g0  = 1'b0;
        g1  = 1'b0;
        win = (rd0_v && rd1_v) ? fav : rd1_v;
        raddr = win ? rd1_addr : rd0_addr;
        if ((rd0_v || rd1_v) && !(wr_v && (wr_addr == raddr))) begin
            g0 = !win;
            g1 = win;
            if (rd0_v && rd1_v) fav = !win;
            exp_q.push_back({win, ref_mem[raddr]});
        end
        chk({tag, ":rd0_rdy"}, 128'(rd0_rdy), 128'(g0));
        chk({tag, ":rd1_rdy"}, 128'(rd1_rdy), 128'(g1));
        chk({tag, ":wr_rdy"}, 128'(wr_rdy), 128'(wr_v));
        chk({tag, ":mem_re"}, 128'(mem_re), 128'(g0 | g1));
        if (g0 | g1) chk({tag, ":mem_raddr"}, 128'(mem_raddr), 128'(raddr));
        chk({tag, ":mem_we"}, 128'(mem_we), 128'(wr_v));
        if (wr_v) begin
            chk({tag, ":mem_waddr"}, 128'(mem_waddr), 128'(wr_addr));
            chk({tag, ":mem_wdata"}, 128'(mem_wdata), 128'(wr_data));
            ref_mem[wr_addr] = wr_data;
        end
        last_g0 = g0;
        last_g1 = g1;
        @(negedge clk);
    endtask

    function automatic logic [2:0] pu_state(input int c);
        if (c == 0) return S_OFF;
        if (c <= PWRUP_CYC) return S_PWRUP;
        return S_ISOL;
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        cfg_pg_en = 1'b1;
        echo_hold_high = 1'b0;
        rd0_v = 1'b0; rd1_v = 1'b0; wr_v = 1'b0;
        rd0_addr = '0; rd1_addr = '0; wr_addr = '0; wr_data = '0;
        last_g0 = 1'b0; last_g1 = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);

        // Reset state
        #1;
        chk_pwr("reset", S_OFF);
        chk("reset:rdata_v", 128'(rdata_v), 128'(0));
        chk("reset:rdata_id", 128'(rdata_id), 128'(0));
        @(negedge clk);

        // Power-up on a read request with the echo tied
        rst = 1'b0;
        rd0_v = 1'b1;
        rd0_addr = 5'd3;
        for (int c = 0; c <= PWRUP_CYC + ISOL_CYC; c++) begin
            #1;
            chk_pwr("pwrup", pu_state(c));
            @(negedge clk);
        end
        #1;
        chk("pwrup:rd0_rdy_c11", 128'(rd0_rdy), 128'(1));
        on_cycle("pwrup_grant");
        rd0_v = 1'b0;
        cfg_pg_en = 1'b0;
        #1;
        chk("pwrup:ret_id", 128'(rdata_id), 128'(0));
        on_cycle("pwrup_ret");

        // Fill a few RF entries
        for (int a = 0; a < 8; a++) begin
            wr_v = 1'b1;
            wr_addr = 5'(a);
            wr_data = {$urandom(), $urandom(), $urandom()};
            on_cycle("fill");
        end
        wr_v = 1'b0;

        // Round-robin with both readers held valid
        rd0_v = 1'b1; rd0_addr = 5'd1;
        rd1_v = 1'b1; rd1_addr = 5'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("arb:rd0_rdy", 128'(rd0_rdy), 128'(k % 2 == 0));
            chk("arb:rd1_rdy", 128'(rd1_rdy), 128'(k % 2 == 1));
            on_cycle("arb");
        end
        rd0_v = 1'b0; rd1_v = 1'b0;
        on_cycle("arb_tail");

        // Write/read address collision with the favoured reader
        wr_v = 1'b1; wr_addr = 5'd5; wr_data = {$urandom(), $urandom(), $urandom()};
        rd0_v = 1'b1; rd0_addr = 5'd5;
        rd1_v = 1'b1; rd1_addr = 5'd6;
        #1;
        chk("coll:wr_rdy", 128'(wr_rdy), 128'(1));
        chk("coll:rd0_rdy", 128'(rd0_rdy), 128'(0));
        chk("coll:rd1_rdy", 128'(rd1_rdy), 128'(0));
        on_cycle("coll");
        wr_v = 1'b0;
        #1;
        chk("coll_next:rd0_rdy", 128'(rd0_rdy), 128'(1));
        on_cycle("coll_next");
        rd0_v = 1'b0;
        on_cycle("coll_rd1");
        rd1_v = 1'b0;
        on_cycle("coll_tail");

        // Randomized traffic respecting hold-until-ready
        p0 = 1'b0; p1 = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!p0) begin
                rd0_v = ($urandom_range(0, 1) == 1);
                rd0_addr = 5'($urandom_range(0, 7));
            end
            if (!p1) begin
                rd1_v = ($urandom_range(0, 1) == 1);
                rd1_addr = 5'($urandom_range(0, 7));
            end
            wr_v = ($urandom_range(0, 2) == 0);
            wr_addr = 5'($urandom_range(0, 7));
            wr_data = {$urandom(), $urandom(), $urandom()};
            on_cycle("rand");
            p0 = rd0_v && !last_g0;
            p1 = rd1_v && !last_g1;
        end
        wr_v = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (!p0) rd0_v = 1'b0;
            if (!p1) rd1_v = 1'b0;
            on_cycle("drain");
            p0 = rd0_v && !last_g0;
            p1 = rd1_v && !last_g1;
        end
        rd0_v = 1'b0; rd1_v = 1'b0;
        on_cycle("drain_end");

        // cfg_pg_en=0 holds ON well past the idle limit (counter must saturate)
        for (int n = 0; n < 150; n++) on_cycle("hold_on");
        cfg_pg_en = 1'b1;
        on_cycle("pgen_rise");
        #1; chk_pwr("pwrdn", S_PWRDN); @(negedge clk);
        #1; chk_pwr("off", S_OFF); @(negedge clk);
        #1; chk_pwr("off_hold", S_OFF); @(negedge clk);

        // Fresh power-up, then count idle cycles to auto power-down
        rd0_v = 1'b1; rd0_addr = 5'd1;
        for (int c = 0; c <= PWRUP_CYC + ISOL_CYC; c++) begin
            #1;
            chk_pwr("pu2", pu_state(c));
            @(negedge clk);
        end
        on_cycle("pu2_grant");
        rd0_v = 1'b0;
        for (int k = 0; k <= IDLE_TO; k++) on_cycle("idle_on");
        cfg_pg_en = 1'b0;
        #1; chk_pwr("idle_pwrdn", S_PWRDN); @(negedge clk);
        #1; chk_pwr("pwrdn_to_off", S_OFF); @(negedge clk);

        // cfg_pg_en=0 powers back up; reset pulsed during ISOL
        for (int c = 1; c <= PWRUP_CYC + 1; c++) begin
            if (c == PWRUP_CYC + 1) rst = 1'b1;
            #1;
            chk_pwr("pu3", pu_state(c));
            @(negedge clk);
        end
        rst = 1'b0;
        clear_model();
        echo_hold_high = 1'b1;
        rd0_v = 1'b1; rd0_addr = 5'd2;
        #1;
        chk_pwr("midrst", S_OFF);
        @(negedge clk);

        // Power-good echo held high: stuck in PWRUP with no grants
        for (int c = 1; c <= 25; c++) begin
            #1;
            chk_pwr("pgood_wait", S_PWRUP);
            @(negedge clk);
        end
        echo_hold_high = 1'b0;
        #1; chk_pwr("pgood_fall", S_PWRUP); @(negedge clk);
        #1; chk_pwr("pgood_isol0", S_ISOL); @(negedge clk);
        #1; chk_pwr("pgood_isol1", S_ISOL); @(negedge clk);

        // Reset in the grant cycle drops the returning read
        rst = 1'b1;
        #1;
        chk("pgood:rd0_rdy", 128'(rd0_rdy), 128'(1));
        chk_pwr("pgood_on", S_ON);
        @(negedge clk);
        rst = 1'b0;
        rd0_v = 1'b0;
        cfg_pg_en = 1'b1;
        #1;
        chk("drop:rdata_v", 128'(rdata_v), 128'(0));
        chk_pwr("drop_off", S_OFF);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
